pc_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next-generation core. It replaces the fixed-length fetch counter and hard-coded end-of-program compare with a start/done handshake, a configurable program length, a writable jump-target table, stall support and a hardware call/return stack with error detection. It sits between the control decoder and the instruction ROM, and drives the fetch address and the core's `done` flag.

---
 rtl/pc_sequencer_if.sv | 33 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/table/status bundle between decoder and pc_sequencer
interface pc_sequencer_if #(
    parameter int PC_W   = 12,
    parameter int JPTR_W = 5
);
    logic              start;
    logic              stall;
    logic              jen;
    logic              cond;
    logic              call;
    logic              ret;
    logic              halt;
    logic [JPTR_W-1:0] jptr;
    logic              lut_we;
    logic [JPTR_W-1:0] lut_waddr;
    logic [PC_W-1:0]   lut_wdata;
    logic [PC_W-1:0]   pc;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, stall, jen, cond, call, ret, halt, jptr,
        output lut_we, lut_waddr, lut_wdata,
        input  pc, busy, done, err
    );

    modport slave (
        input  start, stall, jen, cond, call, ret, halt, jptr,
        input  lut_we, lut_waddr, lut_wdata,
        output pc, busy, done, err
    );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer with jump table and call/return stack
module pc_sequencer #(
    parameter int PC_W        = 12,
    parameter int JPTR_W      = 5,
    parameter int PROG_LEN    = 200,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);
    localparam int              SP_W    = $clog2(STACK_DEPTH + 1);
    localparam int              N_TBL   = 1 << JPTR_W;
    localparam int              N_STK   = 1 << SP_W;
    localparam logic [PC_W:0]   LEN     = (PC_W + 1)'(PROG_LEN);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t          state, nxt_state;
    logic [PC_W-1:0] pc_r, nxt_pc;
    logic [SP_W-1:0] sp, nxt_sp, sp_dec;
    logic            push;
    logic            adv;
    logic            busy_r, done_r, err_r;
    logic [PC_W:0]   pc_inc, cand;
    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] tbl [N_TBL];
    logic [PC_W-1:0] stk [N_STK];

    // One extra bit so the end-of-program compare never sees a wrapped PC.
    assign pc_inc = {1'b0, pc_r} + (PC_W + 1)'(1);
    assign tgt    = tbl[bus.jptr];
    assign sp_dec = sp - SP_W'(1);

    always_comb begin
        nxt_state = state;
        nxt_pc    = pc_r;
        nxt_sp    = sp;
        push      = 1'b0;
        adv       = 1'b0;
        cand      = '0;
        case (state)
            RUN: begin
                if (!bus.stall) begin
                    if (bus.halt) begin
                        nxt_state = DONE;
                    end else if (bus.ret) begin
                        if (sp == '0) begin
                            nxt_state = ERR;
                        end else begin
                            adv    = 1'b1;
                            cand   = {1'b0, stk[sp_dec]};
                            nxt_sp = sp_dec;
                        end
                    end else if (bus.call) begin
                        if (sp == SP_FULL) begin
                            nxt_state = ERR;
                        end else begin
                            adv    = 1'b1;
                            cand   = {1'b0, tgt};
                            nxt_sp = sp + SP_W'(1);
                            push   = 1'b1;
                        end
                    end else if (bus.jen && bus.cond) begin
                        adv  = 1'b1;
                        cand = {1'b0, tgt};
                    end else begin
                        adv  = 1'b1;
                        cand = pc_inc;
                    end
                    // An out-of-range target ends the program without touching pc or stack.
                    if (adv) begin
                        if (cand >= LEN) begin
                            nxt_state = DONE;
                            nxt_sp    = sp;
                            push      = 1'b0;
                        end else begin
                            nxt_pc = cand[PC_W-1:0];
                        end
                    end
                end
            end
            default: begin
                if (bus.start) begin
                    nxt_state = RUN;
                    nxt_pc    = '0;
                    nxt_sp    = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            pc_r   <= '0;
            sp     <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            state  <= nxt_state;
            pc_r   <= nxt_pc;
            sp     <= nxt_sp;
            busy_r <= (nxt_state == RUN);
            done_r <= (nxt_state == DONE) || (nxt_state == ERR);
            err_r  <= (nxt_state == ERR);
        end
    end

    // Stack contents survive restarts; only sp is reset.
    always_ff @(posedge clk) begin
        if (push) begin
            stk[sp] <= pc_inc[PC_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_TBL; i++) begin
                tbl[i] <= '0;
            end
        end else if (bus.lut_we) begin
            tbl[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.pc   = pc_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.err  = err_r;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed vector bench for pc_sequencer
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(12), .JPTR_W(5)) bus ();

    pc_sequencer #(
        .PC_W(12), .JPTR_W(5), .PROG_LEN(200), .STACK_DEPTH(4)
    ) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        start, stall, jen, cond, call, ret, halt;
        logic [4:0]  jptr;
        logic [11:0] pc;
        logic        busy, done, err;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic st, sl, j, c, ca, r, h, input logic [4:0] p,
                        input logic [11:0] epc, input logic eb, ed, ee);
        vec_t v;
        v.start = st; v.stall = sl; v.jen = j; v.cond = c;
        v.call = ca; v.ret = r; v.halt = h; v.jptr = p;
        v.pc = epc; v.busy = eb; v.done = ed; v.err = ee;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic [11:0] epc, input logic eb, ed, ee);
        chk({nm, "_pc"}, 32'(bus.pc), 32'(epc));
        chk({nm, "_flags(busy,done,err)"}, 32'({bus.busy, bus.done, bus.err}), 32'({eb, ed, ee}));
    endtask

    task automatic clear_ctl();
        bus.start = 0; bus.stall = 0; bus.jen = 0; bus.cond = 0;
        bus.call = 0; bus.ret = 0; bus.halt = 0; bus.jptr = '0;
        bus.lut_we = 0; bus.lut_waddr = '0; bus.lut_wdata = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [11:0] d);
        bus.lut_we = 1; bus.lut_waddr = a; bus.lut_wdata = d;
        step();
        bus.lut_we = 0;
    endtask

    task automatic jump(input logic [4:0] p);
        bus.jen = 1; bus.cond = 1; bus.jptr = p;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int exp_pc;
        clear_ctl();
        step();
        step();
        chk_out("reset", 12'd0, 0, 0, 0);
        rst = 1;

        lut_write(5'd3, 12'd40);
        lut_write(5'd1, 12'd100);
        lut_write(5'd2, 12'd150);
        lut_write(5'd7, 12'd250);
        chk_out("idle_after_writes", 12'd0, 0, 0, 0);

        // Linear run to end of program
        bus.start = 1;
        step();
        bus.start = 0;
        busy_cnt = 0;
        exp_pc = 0;
        while (bus.busy && busy_cnt < 250) begin
            chk("lin_pc", 32'(bus.pc), 32'(exp_pc));
            busy_cnt++;
            exp_pc++;
            step();
        end
        chk("lin_busy_cycles", 32'(busy_cnt), 32'd200);
        chk_out("lin_end", 12'd199, 0, 1, 0);

        //   st sl jen c call ret halt jptr   pc  b  d  e
        addv(1, 0, 0, 0, 0, 0, 0, 5'd0, 12'd0,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd1,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd2,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd3,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd4,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd5,   1, 0, 0);
        addv(0, 0, 1, 1, 0, 0, 0, 5'd3, 12'd40,  1, 0, 0);
        addv(0, 0, 1, 0, 0, 0, 0, 5'd3, 12'd41,  1, 0, 0);
        addv(0, 0, 0, 0, 1, 0, 0, 5'd1, 12'd100, 1, 0, 0);
        addv(0, 0, 0, 0, 0, 0, 0, 5'd0, 12'd101, 1, 0, 0);
        addv(0, 0, 0, 0, 1, 0, 0, 5'd1, 12'd100, 1, 0, 0);
        addv(0, 0, 0, 0, 0, 1, 0, 5'd0, 12'd102, 1, 0, 0);
        addv(0, 0, 0, 0, 0, 1, 0, 5'd0, 12'd42,  1, 0, 0);
        addv(0, 1, 1, 1, 0, 0, 0, 5'd3, 12'd42,  1, 0, 0);
        addv(0, 1, 0, 0, 0, 0, 1, 5'd0, 12'd42,  1, 0, 0);
        addv(1, 1, 0, 0, 0, 0, 0, 5'd0, 12'd42,  1, 0, 0);
        addv(0, 0, 1, 1, 0, 0, 0, 5'd7, 12'd42,  0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 5'd0, 12'd0,   1, 0, 0);
        addv(0, 0, 0, 0, 0, 1, 0, 5'd0, 12'd0,   0, 1, 1);
        addv(1, 0, 0, 0, 0, 0, 0, 5'd0, 12'd0,   1, 0, 0);
        addv(0, 0, 1, 1, 0, 1, 1, 5'd3, 12'd0,   0, 1, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 5'd0, 12'd0,   1, 0, 0);
        addv(0, 0, 1, 1, 0, 0, 0, 5'd2, 12'd150, 1, 0, 0);
        addv(1, 0, 0, 0, 0, 0, 0, 5'd0, 12'd151, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.start = vecs[i].start; bus.stall = vecs[i].stall;
            bus.jen = vecs[i].jen; bus.cond = vecs[i].cond;
            bus.call = vecs[i].call; bus.ret = vecs[i].ret;
            bus.halt = vecs[i].halt; bus.jptr = vecs[i].jptr;
            step();
            chk_out($sformatf("vec%0d", i), vecs[i].pc, vecs[i].busy, vecs[i].done, vecs[i].err);
        end
        clear_ctl();

        // Same-cycle table write and read sees the old entry
        jump(5'd3);
        bus.lut_we = 1; bus.lut_waddr = 5'd3; bus.lut_wdata = 12'd60;
        step();
        clear_ctl();
        chk_out("wr_rd_same_cycle", 12'd40, 1, 0, 0);
        jump(5'd3);
        step();
        clear_ctl();
        chk_out("wr_visible_next", 12'd60, 1, 0, 0);

        // Three stalled cycles with a jump pending; table write goes through meanwhile
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1;
            jump(5'd3);
            if (i == 0) begin
                bus.lut_we = 1; bus.lut_waddr = 5'd5; bus.lut_wdata = 12'd77;
            end
            step();
            clear_ctl();
            chk_out($sformatf("stall%0d", i), 12'd60, 1, 0, 0);
        end
        jump(5'd5);
        step();
        clear_ctl();
        chk_out("stall_table_write", 12'd77, 1, 0, 0);

        // Stack overflow on the fifth nested call
        for (int i = 0; i < 4; i++) begin
            bus.call = 1; bus.jptr = 5'd1;
            step();
            chk_out($sformatf("call%0d", i), 12'd100, 1, 0, 0);
        end
        step();
        clear_ctl();
        chk_out("overflow", 12'd100, 0, 1, 1);
        bus.start = 1;
        step();
        clear_ctl();
        chk_out("restart_after_err", 12'd0, 1, 0, 0);
        bus.ret = 1;
        step();
        clear_ctl();
        chk_out("sp_reset_on_restart", 12'd0, 0, 1, 1);

        // Asynchronous reset in the middle of a run clears the table
        bus.start = 1;
        step();
        clear_ctl();
        step();
        step();
        chk_out("pre_reset_run", 12'd2, 1, 0, 0);
        #2 rst = 0;
        #1 chk_out("async_reset", 12'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        jump(5'd3);
        step();
        clear_ctl();
        chk_out("idle_ignores_jump", 12'd0, 0, 0, 0);
        bus.start = 1;
        step();
        clear_ctl();
        jump(5'd3);
        step();
        clear_ctl();
        chk_out("table_cleared", 12'd0, 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
